// File: rtl/fetch_decode.sv
// fetch_decode: instruction fetch and OP-IMM decode front end.
// Fetches 32-bit words over a req/resp handshake, decodes ADDI/SLLI into an
// execute command and buffers commands in a 2-entry FIFO for the execute stage.
// Any other encoding halts fetch and latches a sticky illegal flag plus its pc.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   imem_req_valid/addr/ready       fetch request handshake
//   imem_resp_valid/data            instruction response (one cycle each)
//   out_valid/ready                 downstream command handshake
//   out_op/dst/src1/imm/pc          head-of-FIFO command fields
//   illegal, illegal_pc             sticky illegal flag and offending address

package fetch_decode_pkg;
  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SHL = 1'b1
  } alu_op_t;

  typedef logic [4:0] reg_addr_t;
endpackage

module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [31:0]     imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output alu_op_t         out_op,
  output reg_addr_t       out_dst,
  output reg_addr_t       out_src1,
  output logic [XLEN-1:0] out_imm,
  output logic [31:0]     out_pc,
  output logic            illegal,
  output logic [31:0]     illegal_pc
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_SLLI    = 3'b001;

  typedef struct packed {
    alu_op_t         op;
    reg_addr_t       dst;
    reg_addr_t       src1;
    logic [XLEN-1:0] imm;
    logic [31:0]     pc;
  } cmd_t;

  // BOOT gives one reset-exit cycle so the request comes up one edge after rst_n rises
  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_STALL = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic        req_valid_q;
  cmd_t        head_q, head_d;
  cmd_t        tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic        valid_q;
  logic        illegal_q;
  logic [31:0] illegal_pc_q;

  cmd_t        dec_cmd;
  logic        dec_legal;
  logic        push;
  logic        pop;
  logic        halt_set;
  logic        credit;

  // Decode of the response word into a command
  always_comb begin
    dec_legal    = 1'b0;
    dec_cmd      = '0;
    dec_cmd.op   = ALU_ADD;
    dec_cmd.dst  = imem_resp_data[11:7];
    dec_cmd.src1 = imem_resp_data[19:15];
    dec_cmd.pc   = pc_q;
    if (imem_resp_data[6:0] == OPC_OP_IMM) begin
      if (imem_resp_data[14:12] == F3_ADDI) begin
        dec_legal   = 1'b1;
        dec_cmd.imm = {{(XLEN-12){imem_resp_data[31]}}, imem_resp_data[31:20]};
      end else if (imem_resp_data[14:12] == F3_SLLI && imem_resp_data[31:25] == 7'b0) begin
        dec_legal   = 1'b1;
        dec_cmd.op  = ALU_SHL;
        dec_cmd.imm = XLEN'(imem_resp_data[24:20]);
      end
    end
  end

  assign push     = (state_q == S_WAIT) && imem_resp_valid && dec_legal;
  assign halt_set = (state_q == S_WAIT) && imem_resp_valid && !dec_legal;
  assign pop      = valid_q && out_ready;

  // FIFO next state; head_q always holds the oldest entry
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = dec_cmd;
        else                 tail_d = dec_cmd;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) head_d = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          head_d = tail_q;
          tail_d = dec_cmd;
        end else begin
          head_d = dec_cmd;
        end
      end
      default: ;
    endcase
  end

  // A new request fits only if the FIFO will hold at most one entry
  assign credit = (count_d <= 2'd1);

  // Fetch FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:  state_d = S_REQ;
      S_REQ:   if (imem_req_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (dec_legal) state_d = credit ? S_REQ : S_STALL;
          else           state_d = S_HALT;
        end
      end
      S_STALL: if (credit) state_d = S_REQ;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      req_valid_q  <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= 2'd0;
      valid_q      <= 1'b0;
      illegal_q    <= 1'b0;
      illegal_pc_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= (state_d == S_REQ);
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_q     <= (count_d != 2'd0);
      if (push) pc_q <= pc_q + 32'd4;
      if (halt_set) begin
        illegal_q    <= 1'b1;
        illegal_pc_q <= pc_q;
      end
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign out_valid      = valid_q;
  assign out_op         = head_q.op;
  assign out_dst        = head_q.dst;
  assign out_src1       = head_q.src1;
  assign out_imm        = head_q.imm;
  assign out_pc         = head_q.pc;
  assign illegal        = illegal_q;
  assign illegal_pc     = illegal_pc_q;

endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: scoreboard bench for fetch_decode.
// A memory model answers fetch requests from a small program array; the
// sequencer loads programs and queues the commands each one should produce;
// a monitor pops and compares whenever a command is consumed downstream.
`timescale 1ns/1ps
module tb_fetch_decode;
  import fetch_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  alu_op_t     out_op;
  reg_addr_t   out_dst;
  reg_addr_t   out_src1;
  logic [31:0] out_imm;
  logic [31:0] out_pc;
  logic        illegal;
  logic [31:0] illegal_pc;

  fetch_decode #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_op         (out_op),
    .out_dst        (out_dst),
    .out_src1       (out_src1),
    .out_imm        (out_imm),
    .out_pc         (out_pc),
    .illegal        (illegal),
    .illegal_pc     (illegal_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [4:0]  dst;
    logic [4:0]  src1;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [0:15];
  logic [31:0] req_log[$];
  int          req_count = 0;
  int          mem_lat = 0;
  logic        mem_ready = 1'b1;
  logic        inject = 1'b0;
  logic [31:0] inject_data = 32'h0;
  int          n_checks = 0;
  int          n_fail = 0;

  localparam logic [31:0] ILL = 32'h0000_0033;

  assign imem_req_ready = mem_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic op, input logic [4:0] d, input logic [4:0] s,
                          input logic [31:0] imm, input logic [31:0] pc);
    exp_t e;
    e.op = op; e.dst = d; e.src1 = s; e.imm = imm; e.pc = pc;
    exp_q.push_back(e);
  endtask

  // Memory model: latency mem_lat cycles after the handshake, one-cycle response
  initial begin
    logic        pending;
    int          lat_cnt;
    logic [31:0] pend_addr;
    pending = 1'b0;
    lat_cnt = 0;
    pend_addr = 32'h0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    forever begin
      @(negedge clk);
      imem_resp_valid = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
        req_count = 0;
        req_log.delete();
      end else if (pending) begin
        if (lat_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data = mem[pend_addr[5:2]];
          pending = 1'b0;
        end else begin
          lat_cnt--;
        end
      end else if (imem_req_valid && imem_req_ready) begin
        pending = 1'b1;
        lat_cnt = mem_lat;
        pend_addr = imem_req_addr;
        req_count++;
        req_log.push_back(imem_req_addr);
      end
      if (inject) begin
        imem_resp_valid = 1'b1;
        imem_resp_data = inject_data;
      end
    end
  end

  // Monitor: every consumed command is checked against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_cmd: got pc 0x%08h dst %0d, expected no command", out_pc, out_dst);
        end else begin
          e = exp_q.pop_front();
          chk("cmd_op",   32'(out_op),   32'(e.op));
          chk("cmd_dst",  32'(out_dst),  32'(e.dst));
          chk("cmd_src1", 32'(out_src1), 32'(e.src1));
          chk("cmd_imm",  out_imm,       e.imm);
          chk("cmd_pc",   out_pc,        e.pc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) mem[i] = ILL;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    inject = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 300) begin
      step(1);
      i++;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_illegal(input string name);
    int i;
    i = 0;
    while (!illegal && i < 300) begin
      step(1);
      i++;
    end
    @(negedge clk);
    chk({name, "_illegal"}, 32'(illegal), 32'd1);
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    out_ready = 1'b1;
    fill_mem();

    // Reset values while held, then the first request right after release
    mem[0] = 32'h00A0_0093;
    mem[1] = 32'h0030_9093;
    mem[2] = 32'hFFF0_8113;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid",  32'(imem_req_valid), 32'd0);
    chk("rst_req_addr",   imem_req_addr,       32'h0);
    chk("rst_out_valid",  32'(out_valid),      32'd0);
    chk("rst_out_op",     32'(out_op),         32'(ALU_ADD));
    chk("rst_out_imm",    out_imm,             32'h0);
    chk("rst_illegal",    32'(illegal),        32'd0);
    chk("rst_illegal_pc", illegal_pc,          32'h0);
    step(1);
    rst_n = 1'b1;
    push_exp(1'b0, 5'd1, 5'd0, 32'd10,         32'h0);
    push_exp(1'b1, 5'd1, 5'd1, 32'd3,          32'h4);
    push_exp(1'b0, 5'd2, 5'd1, 32'hFFFF_FFFF,  32'h8);
    @(posedge clk);
    @(negedge clk);
    chk("boot_req_valid", 32'(imem_req_valid), 32'd1);
    chk("boot_req_addr",  imem_req_addr,       32'h0);
    chk("boot_out_valid", 32'(out_valid),      32'd0);
    chk("boot_illegal",   32'(illegal),        32'd0);
    step(1);

    // Decode: ADDI, SLLI, ADDI with negative immediate, then an illegal word at pc 12
    wait_drain("decode");
    wait_illegal("decode");
    chk("decode_illegal_pc", illegal_pc, 32'hC);

    // Backpressure: only two words may be accepted while out_ready is low
    fill_mem();
    mem[0] = 32'h0010_0193;
    mem[1] = 32'h0020_0213;
    mem[2] = 32'h0030_0293;
    mem[3] = 32'h0040_0313;
    mem_lat = 0;
    out_ready = 1'b0;
    do_reset();
    push_exp(1'b0, 5'd3, 5'd0, 32'd1, 32'h0);
    push_exp(1'b0, 5'd4, 5'd0, 32'd2, 32'h4);
    push_exp(1'b0, 5'd5, 5'd0, 32'd3, 32'h8);
    push_exp(1'b0, 5'd6, 5'd0, 32'd4, 32'hC);
    step(20);
    @(negedge clk);
    chk("bp_req_count", 32'(req_count),       32'd2);
    chk("bp_req_valid", 32'(imem_req_valid),  32'd0);
    chk("bp_out_valid", 32'(out_valid),       32'd1);
    chk("bp_head_pc",   out_pc,               32'h0);
    chk("bp_head_dst",  32'(out_dst),         32'd3);
    step(1);
    out_ready = 1'b1;
    wait_drain("bp");
    wait_illegal("bp");
    chk("bp_illegal_pc", illegal_pc, 32'h10);
    chk("bp_resume_pc", (req_log.size() > 2) ? req_log[2] : 32'hFFFF_FFFF, 32'h8);

    // Illegal at pc 4 while the ADDI from pc 0 is still buffered
    fill_mem();
    mem[0] = 32'h00A0_0093;
    out_ready = 1'b0;
    do_reset();
    push_exp(1'b0, 5'd1, 5'd0, 32'd10, 32'h0);
    step(15);
    @(negedge clk);
    chk("ill_flag",      32'(illegal),        32'd1);
    chk("ill_pc",        illegal_pc,          32'h4);
    chk("ill_out_valid", 32'(out_valid),      32'd1);
    chk("ill_req_count", 32'(req_count),      32'd2);
    chk("ill_req_valid", 32'(imem_req_valid), 32'd0);
    step(1);
    out_ready = 1'b1;
    wait_drain("ill");
    step(3);
    @(negedge clk);
    chk("ill_empty",      32'(out_valid), 32'd0);
    chk("ill_no_refetch", 32'(req_count), 32'd2);
    step(1);

    // SLLI with non-zero funct7 is illegal
    fill_mem();
    mem[0] = 32'h4030_9093;
    do_reset();
    wait_illegal("slli_f7");
    @(negedge clk);
    chk("slli_f7_pc",        illegal_pc,     32'h0);
    chk("slli_f7_out_valid", 32'(out_valid), 32'd0);
    step(1);

    // Reset during WAIT, then a stale response before the new request is accepted
    fill_mem();
    mem[0] = 32'h00A0_0093;
    mem_lat = 3;
    mem_ready = 1'b1;
    do_reset();
    push_exp(1'b0, 5'd1, 5'd0, 32'd10, 32'h0);
    for (int i = 0; i < 50 && req_count == 0; i++) step(1);
    chk("stale_first_req", 32'(req_count), 32'd1);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    step(2);
    rst_n = 1'b1;
    inject_data = ILL;
    inject = 1'b1;
    step(2);
    inject = 1'b0;
    @(negedge clk);
    chk("stale_illegal",   32'(illegal),        32'd0);
    chk("stale_req_valid", 32'(imem_req_valid), 32'd1);
    chk("stale_req_addr",  imem_req_addr,       32'h0);
    chk("stale_out_valid", 32'(out_valid),      32'd0);
    step(1);
    mem_ready = 1'b1;
    wait_drain("stale");
    wait_illegal("stale");
    chk("stale_illegal_pc", illegal_pc, 32'h4);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Front-end stage that feeds the execute stage: it fetches 32-bit RISC-V instruction words from instruction memory over a request/response handshake and decodes the supported OP-IMM subset into an execute-stage command: ALU op, destination register, source register and immediate. Decoded commands are buffered in a 2-entry FIFO and presented downstream over a valid/ready handshake. Any unsupported encoding halts fetch and raises a sticky illegal flag.

## Interface
- XLEN, 32, data width of the immediate output (matches `Reg`)
- RESET_PC, 0, address of the first fetch after reset
- clk  in  1  rising-edge clock; one clock domain
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address, always 4-byte aligned
- imem_req_ready  in  1  memory accepts the request
- imem_resp_valid  in  1  instruction word valid, one cycle per response
- imem_resp_data  in  32  instruction word
- out_valid  out  1  decoded command available
- out_ready  in  1  execute stage consumes the command
- out_op  out  AluOp  ALU operation
- out_dst  out  RegAddress  rd field
- out_src1  out  RegAddress  rs1 field
- out_imm  out  XLEN  operand 2
- out_pc  out  32  address of the presented instruction
- illegal  out  1  sticky; an unsupported instruction was fetched
- illegal_pc  out  32  address of the offending instruction

## Operation
- Supported encodings, opcode[6:0] = 7'b0010011:
  - funct3 = 000 (ADDI) → out_op = ADD, out_imm = sign-extended inst[31:20].
  - funct3 = 001 with inst[31:25] = 0 (SLLI) → out_op = SHL, out_imm = zero-extended inst[24:20].
- Every other word is illegal.
- rd = x0 is not special-cased; the command is emitted unchanged.
- FSM states:
  - REQ: imem_req_valid = 1. On imem_req_ready, go to WAIT.
  - WAIT: on imem_resp_valid, decode the word.
    - Legal word: push it to the FIFO with its pc, pc += 4, then go to REQ if credit is available, otherwise STALL.
    - Illegal word: set illegal and illegal_pc, do not push, go to HALT.
  - STALL: go to REQ when credit becomes available.
  - HALT: terminal until reset. No requests are issued.
- Credit rule: FIFO occupancy + outstanding requests ≤ 2. At most one request is outstanding at any time. The credit rule guarantees the FIFO never overflows.
- FIFO: 2 entries, in-order. out_* are driven from the head entry.
  - A pop occurs when out_valid && out_ready.
  - A push and a pop in the same cycle are allowed at any occupancy, including full.
- HALT does not flush the FIFO; entries already buffered still drain normally.
- imem_resp_valid is ignored in REQ, STALL and HALT. This covers stale responses after a reset.
- pc wraps modulo 2^32 (0xFFFFFFFC + 4 → 0).

## Timing
- Reset values while rst_n = 0:
  - imem_req_valid = 0, imem_req_addr = RESET_PC.
  - out_valid = 0, out_op = ADD, out_dst = 0, out_src1 = 0, out_imm = 0, out_pc = 0.
  - illegal = 0, illegal_pc = 0, FIFO empty, pc = RESET_PC.
- The state is REQ on the first clk edge after rst_n rises, so imem_req_valid = 1 in that cycle.
- imem_req_valid and imem_req_addr stay stable until imem_req_ready is seen.
- Response latency from the request handshake is arbitrary, ≥ 1 cycle.
- A response captured at edge N gives out_valid = 1 after edge N; the head registers update at edge N.
- Earliest next request: the cycle after a response is captured, provided credit allows.
- Steady-state throughput with zero-wait memory: 1 instruction per 2 cycles.
- out_* stay stable while out_valid && !out_ready.
- Reset asserted mid-operation clears all state immediately (asynchronous). The outstanding request is abandoned.

## Test plan
- **Reset:** hold rst_n = 0 for 3 cycles, then release → imem_req_valid = 1, imem_req_addr = 0, out_valid = 0, illegal = 0.
- **Decode:** feed 0x00A00093, 0x00309093, 0xFFF08113 with out_ready = 1 → the bench must see these three commands, in order:
  - (ADD, dst 1, src1 0, imm 10, pc 0)
  - (SHL, dst 1, src1 1, imm 3, pc 4)
  - (ADD, dst 2, src1 1, imm 0xFFFFFFFF, pc 8)
- **Backpressure:** hold out_ready = 0 and supply legal words → exactly 2 are accepted, then imem_req_valid stays 0. Raise out_ready → fetch resumes at pc 8 and no command is lost or reordered.
- **Illegal:** 0x00000033 fetched at pc 4 → illegal = 1, illegal_pc = 4, no further requests. The ADDI fetched at pc 0 still drains.
- **Bad SLLI funct7:** 0x40309093 → illegal = 1.
- **Mid-fetch reset and stale response:** assert rst_n = 0 in WAIT, then release; inject imem_resp_valid before the new request is accepted → the stale response is ignored and the first command decoded has pc = RESET_PC.
